interval_sequencer: RTL and testbench
=====================================

// Module: interval_sequencer
// PURPOSE
//  Multi-interval countdown controller for the kitchen/workout timer. Holds NUM_SLOTS programmed
//  durations (1-9 min each) and runs them back to back. Owns the BCD countdown digits shown by
//  display_7_seg: slot number on the thousands digit. Also drives the buzzer enable used by alarm.
//  Button inputs are single-cycle pulses from debouncer trans_dn outputs.
// PARAMETERS
//  CLK_HZ       50000000  clock cycles per one-second tick
//  NUM_SLOTS    4         number of programmable intervals (2..8)
//  CHIRP_SECS   2         seconds of chirp between intervals (1..15)
// PORTS
//  CLK            in   1   system clock
//  RESET          in   1   synchronous, active-high reset
//  s_up           in   1   pulse: selected slot minutes +1
//  s_dn           in   1   pulse: selected slot minutes -1
//  s_next         in   1   pulse: select next slot (SETTING only)
//  s_start_stop   in   1   pulse: start / pause / resume
//  s_cancel       in   1   pulse: abort to SETTING
//  secs           out  4   BCD seconds units 0-9
//  ten_secs       out  4   BCD seconds tens 0-5
//  mins           out  4   BCD minutes 0-9
//  slot_idx       out  4   current slot, zero-extended (0..NUM_SLOTS-1)
//  running        out  1   1 in RUNNING or CHIRP
//  chirp          out  1   1 in CHIRP (short beep between intervals)
//  alarm_on       out  1   1 in DONE (continuous alarm)
// BEHAVIOUR
//  Reset: state=SETTING, all slots=1, slot_idx=0, mins=1, ten_secs=0, secs=0, prescaler=0,
//   running/chirp/alarm_on=0. Reset has priority over every input.
//  All outputs registered; button effects visible on the cycle after the pulse.
//  States: SETTING, RUNNING, PAUSED, CHIRP, DONE.
//  Priority within one cycle: s_cancel > s_start_stop > zero-detect > tick > s_up/s_dn/s_next.
//  Prescaler: counts 0..CLK_HZ-1; tick when it equals CLK_HZ-1 (then wraps to 0).
//   Counts only in RUNNING and CHIRP. Held in PAUSED. Cleared on SETTING->RUNNING and on
//   entering CHIRP.
//  SETTING: mins shows slot[slot_idx], secs=ten_secs=0.
//   s_up: 9->1 wrap. s_dn: 1->9 wrap. s_up and s_dn in the same cycle: no change.
//   s_next: slot_idx+1, NUM_SLOTS-1 wraps to 0.
//   s_start_stop: slot_idx<=0, load mins=slot[0], secs=ten_secs=0, ->RUNNING.
//   s_cancel: slot_idx<=0.
//  RUNNING: on tick decrement the M:SS time.
//   secs 0->9 borrows ten_secs. ten_secs 0->5 borrows mins.
//   Decrement never happens at 0:00.
//   Zero-detect (mins, ten_secs, secs all 0, checked every cycle):
//     slot_idx<NUM_SLOTS-1 -> CHIRP.
//     last slot -> DONE.
//   s_start_stop -> PAUSED. s_cancel -> SETTING.
//  PAUSED: digits and prescaler frozen. s_start_stop -> RUNNING (prescaler resumes where held).
//   s_cancel -> SETTING.
//  CHIRP: digits stay 0:00, chirp=1. After CHIRP_SECS ticks: slot_idx+1, load mins=slot[new],
//   secs=ten_secs=0, ->RUNNING. s_start_stop ignored. s_cancel -> SETTING.
//  DONE: alarm_on=1, digits 0:00. Only s_cancel acts (->SETTING); all other buttons ignored.
//  Any ->SETTING transition: slot_idx=0, mins=slot[0], chirp=alarm_on=0; slot values retained.
//  Slot storage changes only in SETTING via s_up/s_dn; only the selected slot changes.
// TESTING (CLK_HZ=10, NUM_SLOTS=3, CHIRP_SECS=2 unless stated)
//  1. Reset, 2x s_up, s_next, s_dn -> slot0=3, slot1=9, slot_idx=1, mins=9.
//  2. Slots 1,1,1, start -> 1:00, 0:59 after 10 clk.
//     0:00 after 600 clk, chirp=1 for 20 clk.
//     Then slot_idx=1, mins=1, running=1.
//  3. Run all three slots -> after last 0:00, alarm_on=1, DONE.
//     Then s_start_stop/s_up ignored; s_cancel -> SETTING, mins=slot[0], alarm_on=0.
//  4. Start, wait 5 clk, s_start_stop -> time frozen 50 clk.
//     Resume -> next decrement 5 clk later (prescaler held).
//  5. Same-cycle s_cancel + s_start_stop while RUNNING -> SETTING.
//     Same-cycle s_up + s_dn in SETTING -> no change.
//  6. RESET asserted mid-CHIRP -> next cycle all outputs at reset values, slots back to 1.

Source files
------------

// File: rtl/interval_sequencer.sv
// Multi-interval countdown controller: runs NUM_SLOTS programmed minute durations back to back,
// with a short chirp between intervals and a continuous alarm once the last one expires.
module interval_sequencer #(
  parameter int CLK_HZ     = 50000000,
  parameter int NUM_SLOTS  = 4,
  parameter int CHIRP_SECS = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       s_up,
  input  logic       s_dn,
  input  logic       s_next,
  input  logic       s_start_stop,
  input  logic       s_cancel,
  output logic [3:0] secs,
  output logic [3:0] ten_secs,
  output logic [3:0] mins,
  output logic [3:0] slot_idx,
  output logic       running,
  output logic       chirp,
  output logic       alarm_on
);

  localparam int PW    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int IDX_W = $clog2(NUM_SLOTS);

  localparam logic [PW-1:0]    PRESCALE_MAX = PW'(CLK_HZ - 1);
  localparam logic [IDX_W-1:0] LAST_SLOT    = IDX_W'(NUM_SLOTS - 1);
  localparam logic [3:0]       CHIRP_LAST   = 4'(CHIRP_SECS - 1);

  localparam logic [2:0] ST_SETTING = 3'd0;
  localparam logic [2:0] ST_RUNNING = 3'd1;
  localparam logic [2:0] ST_PAUSED  = 3'd2;
  localparam logic [2:0] ST_CHIRP   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [PW-1:0]    prescale_q, prescale_d;
  logic [3:0]       chirp_cnt_q, chirp_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       mins_q, mins_d;
  logic [3:0]       ten_q, ten_d;
  logic [3:0]       secs_q, secs_d;
  logic             running_q, running_d;
  logic             chirp_q, chirp_d;
  logic             alarm_q, alarm_d;
  logic [3:0]       slots_q [NUM_SLOTS];
  logic [3:0]       slots_d [NUM_SLOTS];

  logic tick;
  logic at_zero;
  logic go_setting;

  assign tick    = (prescale_q == PRESCALE_MAX);
  assign at_zero = (mins_q == 4'd0) && (ten_q == 4'd0) && (secs_q == 4'd0);

  always_comb begin
    state_d     = state_q;
    prescale_d  = prescale_q;
    chirp_cnt_d = chirp_cnt_q;
    idx_d       = idx_q;
    mins_d      = mins_q;
    ten_d       = ten_q;
    secs_d      = secs_q;
    slots_d     = slots_q;
    go_setting  = 1'b0;

    case (state_q)
      ST_SETTING: begin
        if (s_cancel) begin
          go_setting = 1'b1;
        end else if (s_start_stop) begin
          state_d    = ST_RUNNING;
          idx_d      = '0;
          mins_d     = slots_q[0];
          ten_d      = 4'd0;
          secs_d     = 4'd0;
          prescale_d = '0;
        end else begin
          // Simultaneous up and down cancel each other out.
          if (s_up && !s_dn) begin
            slots_d[idx_q] = (slots_q[idx_q] == 4'd9) ? 4'd1 : slots_q[idx_q] + 4'd1;
          end else if (s_dn && !s_up) begin
            slots_d[idx_q] = (slots_q[idx_q] == 4'd1) ? 4'd9 : slots_q[idx_q] - 4'd1;
          end
          if (s_next) begin
            idx_d = (idx_q == LAST_SLOT) ? '0 : idx_q + 1'b1;
          end
          mins_d = slots_d[idx_d];
          ten_d  = 4'd0;
          secs_d = 4'd0;
        end
      end

      ST_RUNNING: begin
        if (s_cancel) begin
          go_setting = 1'b1;
        end else if (s_start_stop) begin
          state_d = ST_PAUSED;
        end else if (at_zero) begin
          prescale_d  = '0;
          chirp_cnt_d = 4'd0;
          state_d     = (idx_q == LAST_SLOT) ? ST_DONE : ST_CHIRP;
        end else if (tick) begin
          prescale_d = '0;
          if (secs_q != 4'd0) begin
            secs_d = secs_q - 4'd1;
          end else begin
            secs_d = 4'd9;
            if (ten_q != 4'd0) begin
              ten_d = ten_q - 4'd1;
            end else begin
              ten_d  = 4'd5;
              mins_d = mins_q - 4'd1;
            end
          end
        end else begin
          prescale_d = prescale_q + 1'b1;
        end
      end

      ST_PAUSED: begin
        if (s_cancel) begin
          go_setting = 1'b1;
        end else if (s_start_stop) begin
          state_d = ST_RUNNING;
        end
      end

      ST_CHIRP: begin
        if (s_cancel) begin
          go_setting = 1'b1;
        end else if (tick) begin
          prescale_d = '0;
          if (chirp_cnt_q == CHIRP_LAST) begin
            chirp_cnt_d = 4'd0;
            state_d     = ST_RUNNING;
            idx_d       = idx_q + 1'b1;
            mins_d      = slots_q[idx_q + 1'b1];
            ten_d       = 4'd0;
            secs_d      = 4'd0;
          end else begin
            chirp_cnt_d = chirp_cnt_q + 4'd1;
          end
        end else begin
          prescale_d = prescale_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (s_cancel) begin
          go_setting = 1'b1;
        end
      end

      default: begin
        go_setting = 1'b1;
      end
    endcase

    // Every return to SETTING lands on slot 0 with its stored duration shown.
    if (go_setting) begin
      state_d     = ST_SETTING;
      idx_d       = '0;
      mins_d      = slots_q[0];
      ten_d       = 4'd0;
      secs_d      = 4'd0;
      prescale_d  = '0;
      chirp_cnt_d = 4'd0;
    end

    running_d = (state_d == ST_RUNNING) || (state_d == ST_CHIRP);
    chirp_d   = (state_d == ST_CHIRP);
    alarm_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_SETTING;
      prescale_q  <= '0;
      chirp_cnt_q <= 4'd0;
      idx_q       <= '0;
      mins_q      <= 4'd1;
      ten_q       <= 4'd0;
      secs_q      <= 4'd0;
      running_q   <= 1'b0;
      chirp_q     <= 1'b0;
      alarm_q     <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slots_q[i] <= 4'd1;
      end
    end else begin
      state_q     <= state_d;
      prescale_q  <= prescale_d;
      chirp_cnt_q <= chirp_cnt_d;
      idx_q       <= idx_d;
      mins_q      <= mins_d;
      ten_q       <= ten_d;
      secs_q      <= secs_d;
      running_q   <= running_d;
      chirp_q     <= chirp_d;
      alarm_q     <= alarm_d;
      slots_q     <= slots_d;
    end
  end

  assign secs     = secs_q;
  assign ten_secs = ten_q;
  assign mins     = mins_q;
  assign slot_idx = {{(4 - IDX_W){1'b0}}, idx_q};
  assign running  = running_q;
  assign chirp    = chirp_q;
  assign alarm_on = alarm_q;

endmodule

// File: tb/tb_interval_sequencer.sv
// Directed bench for interval_sequencer with a 10-cycle second, three slots and a two-second chirp.
module tb_interval_sequencer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       s_up = 1'b0;
  logic       s_dn = 1'b0;
  logic       s_next = 1'b0;
  logic       s_start_stop = 1'b0;
  logic       s_cancel = 1'b0;
  logic [3:0] secs;
  logic [3:0] ten_secs;
  logic [3:0] mins;
  logic [3:0] slot_idx;
  logic       running;
  logic       chirp;
  logic       alarm_on;

  int checks = 0;
  int errors = 0;

  interval_sequencer #(
    .CLK_HZ    (10),
    .NUM_SLOTS (3),
    .CHIRP_SECS(2)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .s_up        (s_up),
    .s_dn        (s_dn),
    .s_next      (s_next),
    .s_start_stop(s_start_stop),
    .s_cancel    (s_cancel),
    .secs        (secs),
    .ten_secs    (ten_secs),
    .mins        (mins),
    .slot_idx    (slot_idx),
    .running     (running),
    .chirp       (chirp),
    .alarm_on    (alarm_on)
  );

  always #5 CLK = ~CLK;

  // Every task starts and ends on a falling edge, so each pulse spans exactly one rising edge.
  task automatic applyStimulus(input logic up, input logic dn, input logic nxt,
                               input logic ss, input logic cancel);
    s_up = up; s_dn = dn; s_next = nxt; s_start_stop = ss; s_cancel = cancel;
    @(negedge CLK);
    s_up = 1'b0; s_dn = 1'b0; s_next = 1'b0; s_start_stop = 1'b0; s_cancel = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  initial begin
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    $display("[TB] reset state");
    checkOutput("rst_mins", mins, 4'd1);
    checkOutput("rst_ten", ten_secs, 4'd0);
    checkOutput("rst_secs", secs, 4'd0);
    checkOutput("rst_idx", slot_idx, 4'd0);
    checkOutput("rst_running", {3'b0, running}, 4'd0);
    checkOutput("rst_chirp", {3'b0, chirp}, 4'd0);
    checkOutput("rst_alarm", {3'b0, alarm_on}, 4'd0);

    $display("[TB] programming slots");
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("set_slot0_3", mins, 4'd3);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("set_next_idx1", slot_idx, 4'd1);
    checkOutput("set_next_mins1", mins, 4'd1);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("set_dn_wrap9", mins, 4'd9);
    checkOutput("set_dn_idx", slot_idx, 4'd1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("set_up_wrap1", mins, 4'd1);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("set_idx2", slot_idx, 4'd2);
    checkOutput("set_slot2", mins, 4'd1);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("set_idx_wrap0", slot_idx, 4'd0);
    checkOutput("set_slot0_kept", mins, 4'd3);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("set_updn_nochange", mins, 4'd3);

    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    checkOutput("rst2_mins", mins, 4'd1);

    $display("[TB] first interval and chirp");
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("run_start_mins", mins, 4'd1);
    checkOutput("run_start_running", {3'b0, running}, 4'd1);
    waitCycles(9);
    checkOutput("run_pre_tick_secs", secs, 4'd0);
    checkOutput("run_pre_tick_mins", mins, 4'd1);
    waitCycles(1);
    checkOutput("run_059_secs", secs, 4'd9);
    checkOutput("run_059_ten", ten_secs, 4'd5);
    checkOutput("run_059_mins", mins, 4'd0);
    waitCycles(590);
    checkOutput("run_000_secs", secs, 4'd0);
    checkOutput("run_000_ten", ten_secs, 4'd0);
    checkOutput("run_000_mins", mins, 4'd0);
    checkOutput("run_000_chirp", {3'b0, chirp}, 4'd0);
    waitCycles(1);
    checkOutput("chirp_on", {3'b0, chirp}, 4'd1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("chirp_ss_ignored", {3'b0, chirp}, 4'd1);
    checkOutput("chirp_running", {3'b0, running}, 4'd1);
    waitCycles(18);
    checkOutput("chirp_last_cycle", {3'b0, chirp}, 4'd1);
    waitCycles(1);
    checkOutput("chirp_off", {3'b0, chirp}, 4'd0);
    checkOutput("slot1_idx", slot_idx, 4'd1);
    checkOutput("slot1_mins", mins, 4'd1);
    checkOutput("slot1_running", {3'b0, running}, 4'd1);

    $display("[TB] remaining intervals to alarm");
    waitCycles(621);
    checkOutput("slot2_idx", slot_idx, 4'd2);
    checkOutput("slot2_mins", mins, 4'd1);
    waitCycles(600);
    checkOutput("last_zero_alarm", {3'b0, alarm_on}, 4'd0);
    checkOutput("last_zero_secs", secs, 4'd0);
    waitCycles(1);
    checkOutput("done_alarm", {3'b0, alarm_on}, 4'd1);
    checkOutput("done_running", {3'b0, running}, 4'd0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("done_ss_ignored", {3'b0, alarm_on}, 4'd1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("done_up_ignored", mins, 4'd0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("cancel_alarm_off", {3'b0, alarm_on}, 4'd0);
    checkOutput("cancel_mins", mins, 4'd1);
    checkOutput("cancel_idx", slot_idx, 4'd0);

    $display("[TB] pause and resume");
    applyStimulus(0, 0, 0, 1, 0);
    waitCycles(5);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("pause_running", {3'b0, running}, 4'd0);
    waitCycles(50);
    checkOutput("pause_frozen_mins", mins, 4'd1);
    checkOutput("pause_frozen_secs", secs, 4'd0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("resume_running", {3'b0, running}, 4'd1);
    waitCycles(4);
    checkOutput("resume_before_tick", secs, 4'd0);
    waitCycles(1);
    checkOutput("resume_tick", secs, 4'd9);

    $display("[TB] cancel beats start_stop");
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("cancel_prio_running", {3'b0, running}, 4'd0);
    checkOutput("cancel_prio_mins", mins, 4'd1);
    checkOutput("cancel_prio_secs", secs, 4'd0);
    checkOutput("cancel_prio_ten", ten_secs, 4'd0);

    $display("[TB] reset during chirp");
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("pre_reset_slot1", mins, 4'd2);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("pre_reset_start_idx", slot_idx, 4'd0);
    waitCycles(601);
    checkOutput("pre_reset_chirp", {3'b0, chirp}, 4'd1);
    waitCycles(5);
    RESET = 1'b1;
    s_up = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    s_up = 1'b0;
    checkOutput("chirp_rst_chirp", {3'b0, chirp}, 4'd0);
    checkOutput("chirp_rst_running", {3'b0, running}, 4'd0);
    checkOutput("chirp_rst_alarm", {3'b0, alarm_on}, 4'd0);
    checkOutput("chirp_rst_mins", mins, 4'd1);
    checkOutput("chirp_rst_ten", ten_secs, 4'd0);
    checkOutput("chirp_rst_secs", secs, 4'd0);
    checkOutput("chirp_rst_idx", slot_idx, 4'd0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("chirp_rst_slot1", mins, 4'd1);
    checkOutput("chirp_rst_idx1", slot_idx, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
